// File: rtl/spi_pkg.sv
// Shared definitions for the SPI byte core and the burst controller.
//   SPI_BYTE_W    : byte width moved per core transaction
//   burst_state_e : burst controller FSM states
package spi_pkg;

    localparam int SPI_BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        LOAD,
        WAIT_DONE,
        CS_HOLD
    } burst_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
//   clk, reset       : clock, synchronous active-high reset (flushes contents)
//   wr_en, wr_data   : push; dropped when full
//   rd_en            : pop; ignored when empty
//   rd_data          : head entry, forced to zero while empty
//   full, empty      : occupancy flags
//   count            : occupancy, one bit wider than the pointers
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             push, pop;

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    // Storage is not reset, so mask the head while empty.
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/spi_burst_ctrl.sv
// Multi-byte burst controller in front of the byte-level spi master core.
// Holds ss_n low for a whole burst with CS_CYC cycles of setup and hold,
// feeds TX FIFO bytes into the core's start/ready handshake and captures
// each received byte into an RX FIFO.
//   cmd_valid/cmd_len/cmd_ready : burst request, cmd_len = bytes - 1
//   tx_wr/tx_data/tx_full       : host side of the TX FIFO
//   rx_rd/rx_data/rx_empty      : host side of the RX FIFO (FWFT)
//   busy, xfer_done, ovf_err    : status; ovf_err is sticky until reset
//   ss_n                        : slave select, active low
//   spi_din/spi_start/spi_ready/spi_dout/spi_done_tick : core byte handshake
module spi_burst_ctrl
    import spi_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int CS_CYC = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    input  logic [7:0]            cmd_len,
    output logic                  cmd_ready,
    input  logic                  tx_wr,
    input  logic [SPI_BYTE_W-1:0] tx_data,
    output logic                  tx_full,
    input  logic                  rx_rd,
    output logic [SPI_BYTE_W-1:0] rx_data,
    output logic                  rx_empty,
    output logic                  busy,
    output logic                  xfer_done,
    output logic                  ovf_err,
    output logic                  ss_n,
    output logic [SPI_BYTE_W-1:0] spi_din,
    output logic                  spi_start,
    input  logic                  spi_ready,
    input  logic [SPI_BYTE_W-1:0] spi_dout,
    input  logic                  spi_done_tick
);

    localparam int GAP_W = $clog2(CS_CYC) + 1;
    localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(CS_CYC - 1);

    burst_state_e          state_q, state_d;
    logic [7:0]            remain_q, remain_d;
    logic [GAP_W-1:0]      gap_q, gap_d;
    logic                  ss_n_q, ss_n_d;
    logic                  ovf_q, ovf_d;

    logic                  tx_empty, tx_pop;
    logic [SPI_BYTE_W-1:0] tx_head;
    logic                  rx_full, rx_push;
    logic [$clog2(DEPTH):0] tx_count_unused, rx_count_unused;
    logic                  issue;

    sync_fifo #(.WIDTH(SPI_BYTE_W), .DEPTH(DEPTH)) u_tx_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (tx_wr),
        .wr_data (tx_data),
        .rd_en   (tx_pop),
        .rd_data (tx_head),
        .full    (tx_full),
        .empty   (tx_empty),
        .count   (tx_count_unused)
    );

    sync_fifo #(.WIDTH(SPI_BYTE_W), .DEPTH(DEPTH)) u_rx_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (rx_push),
        .wr_data (spi_dout),
        .rd_en   (rx_rd),
        .rd_data (rx_data),
        .full    (rx_full),
        .empty   (rx_empty),
        .count   (rx_count_unused)
    );

    // RX room is reserved at issue time: only one byte is ever in flight and
    // the host can only drain, so the push on done never meets a full FIFO.
    assign issue     = spi_ready && !tx_empty && !rx_full;
    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign ss_n      = ss_n_q;
    assign ovf_err   = ovf_q;

    always_comb begin
        state_d   = state_q;
        remain_d  = remain_q;
        gap_d     = gap_q;
        tx_pop    = 1'b0;
        rx_push   = 1'b0;
        spi_start = 1'b0;
        spi_din   = '0;
        xfer_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d  = CS_SETUP;
                    remain_d = cmd_len;
                    gap_d    = GAP_INIT;
                end
            end
            CS_SETUP: begin
                if (gap_q == '0) state_d = LOAD;
                else             gap_d   = gap_q - GAP_W'(1);
            end
            LOAD: begin
                if (issue) begin
                    spi_start = 1'b1;
                    spi_din   = tx_head;
                    tx_pop    = 1'b1;
                    state_d   = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (spi_done_tick) begin
                    rx_push = 1'b1;
                    if (remain_q == 8'd0) begin
                        state_d = CS_HOLD;
                        gap_d   = GAP_INIT;
                    end else begin
                        remain_d = remain_q - 8'd1;
                        state_d  = LOAD;
                    end
                end
            end
            CS_HOLD: begin
                if (gap_q == '0) begin
                    xfer_done = 1'b1;
                    state_d   = IDLE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // ss_n is registered from the next state so it deasserts exactly in
        // the final CS_HOLD cycle (the one that pulses xfer_done).
        ss_n_d = (state_d == IDLE) || ((state_d == CS_HOLD) && (gap_d == '0));

        ovf_d = ovf_q | (tx_wr && tx_full) | (rx_rd && rx_empty)
                      | (rx_push && rx_full);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            remain_q <= '0;
            gap_q    <= '0;
            ss_n_q   <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            gap_q    <= gap_d;
            ss_n_q   <= ss_n_d;
            ovf_q    <= ovf_d;
        end
    end

endmodule

// File: tb/tb_spi_burst_ctrl.sv
module tb_spi_burst_ctrl;

    localparam int DEPTH  = 16;
    localparam int CS_CYC = 4;
    localparam int LAT    = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [7:0] cmd_len = 8'd0;
    logic       cmd_ready;
    logic       tx_wr = 1'b0;
    logic [7:0] tx_data = 8'd0;
    logic       tx_full;
    logic       rx_rd = 1'b0;
    logic [7:0] rx_data;
    logic       rx_empty;
    logic       busy, xfer_done, ovf_err, ss_n;
    logic [7:0] spi_din;
    logic       spi_start;
    logic       spi_ready;
    logic [7:0] spi_dout;
    logic       spi_done_tick;

    always #5 clk = ~clk;

    spi_burst_ctrl #(.DEPTH(DEPTH), .CS_CYC(CS_CYC)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_len(cmd_len), .cmd_ready(cmd_ready),
        .tx_wr(tx_wr), .tx_data(tx_data), .tx_full(tx_full),
        .rx_rd(rx_rd), .rx_data(rx_data), .rx_empty(rx_empty),
        .busy(busy), .xfer_done(xfer_done), .ovf_err(ovf_err), .ss_n(ss_n),
        .spi_din(spi_din), .spi_start(spi_start), .spi_ready(spi_ready),
        .spi_dout(spi_dout), .spi_done_tick(spi_done_tick)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
    endtask

    // Loopback core stand-in: busy for LAT+1 cycles after start, then returns
    // the transmitted byte with done. Deliberately not reset, so a byte in
    // flight across a controller reset still produces its done tick.
    int         core_cnt = 0;
    logic [7:0] core_sh = 8'd0;
    initial begin
        logic       st;
        logic [7:0] d;
        spi_ready = 1'b1;
        spi_done_tick = 1'b0;
        spi_dout = 8'd0;
        forever begin
            @(negedge clk);
            st = spi_start;
            d  = spi_din;
            @(posedge clk);
            #1;
            if (st === 1'b1) begin
                core_cnt = LAT; spi_ready = 1'b0; spi_done_tick = 1'b0; core_sh = d;
            end else if (core_cnt > 1) begin
                core_cnt--; spi_done_tick = 1'b0;
            end else if (core_cnt == 1) begin
                core_cnt = 0; spi_done_tick = 1'b1; spi_dout = core_sh; spi_ready = 1'b1;
            end else begin
                spi_done_tick = 1'b0;
            end
        end
    end

    // Transaction-level model: FIFOs as queues, burst as a time window
    // [accept+1, last_done+CS_CYC] and an issue rule from the handshake.
    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    bit  m_active, m_ending, m_pending, m_ovf, chk_on;
    int  m_acc, m_endc, m_len, m_issued, m_done;
    int  n_starts = 0, n_xfer = 0;
    int  acc_cyc = 0, start_cyc = 0, done_cyc = 0, xfer_cyc = 0;
    bit  first_pend = 0;

    task automatic model_reset();
        txq.delete(); rxq.delete();
        m_active = 0; m_ending = 0; m_pending = 0; m_ovf = 0;
        m_acc = 0; m_endc = 0; m_len = 0; m_issued = 0; m_done = 0;
    endtask

    initial begin
        bit exp_busy, exp_ss, exp_x, exp_st, full_b;
        logic [7:0] exp_rd;
        chk_on = 0;
        model_reset();
        forever begin
            @(negedge clk);
            cyc++;
            if (chk_on && !reset) begin
                exp_busy = m_active;
                exp_ss   = !(m_active && !(m_ending && cyc >= m_endc));
                exp_x    = m_active && m_ending && (cyc == m_endc);
                exp_st   = m_active && !m_ending && (cyc >= m_acc + 1 + CS_CYC) &&
                           !m_pending && (m_issued <= m_len) && (spi_ready === 1'b1) &&
                           (txq.size() > 0) && (rxq.size() < DEPTH);
                exp_rd   = (rxq.size() > 0) ? rxq[0] : 8'h00;
                chk("ss_n", ss_n, exp_ss);
                chk("busy", busy, exp_busy);
                chk("cmd_ready", cmd_ready, !exp_busy);
                chk("xfer_done", xfer_done, exp_x);
                chk("spi_start", spi_start, exp_st);
                chk("rx_empty", rx_empty, rxq.size() == 0);
                chk("rx_data", rx_data, exp_rd);
                chk("tx_full", tx_full, txq.size() == DEPTH);
                chk("ovf_err", ovf_err, m_ovf);
                if (exp_st && spi_start === 1'b1) chk("spi_din", spi_din, txq[0]);

                if (cmd_valid && cmd_ready) begin acc_cyc = cyc; first_pend = 1; end
                if (spi_start === 1'b1) begin
                    n_starts++;
                    if (first_pend) begin start_cyc = cyc; first_pend = 0; end
                end
                if (spi_done_tick) done_cyc = cyc;
                if (xfer_done === 1'b1) begin n_xfer++; xfer_cyc = cyc; end

                if (exp_x) m_active = 0;
                full_b = (txq.size() == DEPTH);
                if (exp_st) begin
                    void'(txq.pop_front()); m_issued++; m_pending = 1;
                end
                if (tx_wr) begin
                    if (full_b) m_ovf = 1; else txq.push_back(tx_data);
                end
                if (rx_rd) begin
                    if (rxq.size() > 0) void'(rxq.pop_front()); else m_ovf = 1;
                end
                if (spi_done_tick && m_active && m_pending) begin
                    rxq.push_back(spi_dout);
                    m_pending = 0;
                    m_done++;
                    if (m_done == m_len + 1) begin m_ending = 1; m_endc = cyc + CS_CYC; end
                end
                if (cmd_valid && !exp_busy) begin
                    m_active = 1; m_ending = 0; m_pending = 0;
                    m_acc = cyc; m_len = int'(cmd_len); m_issued = 0; m_done = 0;
                end
            end else if (reset) begin
                model_reset();
                chk_on = 1;
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        reset = 1'b1; tick(); reset = 1'b0;
    endtask

    task automatic push_tx(input logic [7:0] b);
        tx_wr = 1'b1; tx_data = b; tick(); tx_wr = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] len);
        int t = 0;
        while (!cmd_ready && t < 200) begin tick(); t++; end
        if (t >= 200) timeout_fail("cmd_ready_wait");
        cmd_valid = 1'b1; cmd_len = len; tick(); cmd_valid = 1'b0;
    endtask

    task automatic wait_xfer(input int base, input int bound);
        int t = 0;
        while (n_xfer <= base && t < bound) begin tick(); t++; end
        if (n_xfer <= base) timeout_fail("xfer_wait");
    endtask

    task automatic wait_starts(input int target, input int bound);
        int t = 0;
        while (n_starts < target && t < bound) begin tick(); t++; end
        if (n_starts < target) timeout_fail("start_wait");
    endtask

    task automatic pop_chk(input string name, input logic [7:0] exp);
        chk(name, rx_data, exp);
        rx_rd = 1'b1; tick(); rx_rd = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sb, xb, idx, t;
        logic [7:0] pat [4];
        pat[0] = 8'hA1; pat[1] = 8'hB2; pat[2] = 8'hC3; pat[3] = 8'hD4;
        tick(2);
        reset = 1'b0;

        // Reset state
        chk("rst_ss_n", ss_n, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_rx_empty", rx_empty, 1'b1);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_tx_full", tx_full, 1'b0);
        chk("rst_ovf", ovf_err, 1'b0);
        chk("rst_start", spi_start, 1'b0);
        chk("rst_din", spi_din, 8'h00);
        chk("rst_xfer_done", xfer_done, 1'b0);

        // Single byte
        sb = n_starts; xb = n_xfer;
        push_tx(8'h55);
        send_cmd(8'd0);
        wait_xfer(xb, 100);
        chk("single_starts", n_starts - sb, 1);
        chk("single_setup_gap", start_cyc - acc_cyc, 1 + CS_CYC);
        chk("single_hold_gap", xfer_cyc - done_cyc, CS_CYC);
        tick();
        chk("single_ss_n_after", ss_n, 1'b1);
        chk("single_rx_empty", rx_empty, 1'b0);
        pop_chk("single_rx", 8'h55);

        // Four-byte burst
        sb = n_starts; xb = n_xfer;
        for (int i = 0; i < 4; i++) push_tx(pat[i]);
        send_cmd(8'd3);
        wait_xfer(xb, 200);
        chk("burst4_starts", n_starts - sb, 4);
        tick();
        chk("burst4_busy_low", busy, 1'b0);
        for (int i = 0; i < 4; i++) pop_chk("burst4_rx", pat[i]);
        chk("burst4_rx_empty", rx_empty, 1'b1);

        // TX underrun stall
        sb = n_starts; xb = n_xfer;
        push_tx(8'h11);
        send_cmd(8'd1);
        tick(50);
        chk("underrun_starts", n_starts - sb, 1);
        chk("underrun_ss_n", ss_n, 1'b0);
        chk("underrun_busy", busy, 1'b1);
        push_tx(8'h22);
        chk("underrun_resume", spi_start, 1'b1);
        chk("underrun_resume_din", spi_din, 8'h22);
        wait_xfer(xb, 100);
        pop_chk("underrun_rx0", 8'h11);
        pop_chk("underrun_rx1", 8'h22);

        // RX full stall: 20-byte burst, host not popping
        sb = n_starts; xb = n_xfer;
        for (int i = 0; i < 16; i++) push_tx(8'h40 + 8'(i));
        chk("rxfull_tx_full", tx_full, 1'b1);
        send_cmd(8'd19);
        wait_starts(sb + 16, 400);
        for (int i = 16; i < 20; i++) push_tx(8'h40 + 8'(i));
        tick(30);
        chk("rxfull_stall_starts", n_starts - sb, 16);
        chk("rxfull_ss_n", ss_n, 1'b0);
        pop_chk("rxfull_pop0", 8'h40);
        tick(20);
        chk("rxfull_one_more", n_starts - sb, 17);
        idx = 1; t = 0;
        while (idx < 20 && t < 400) begin
            if (!rx_empty) begin
                chk("rxfull_drain", rx_data, 8'h40 + 8'(idx));
                rx_rd = 1'b1; idx++;
            end else begin
                rx_rd = 1'b0;
            end
            tick(); t++;
        end
        rx_rd = 1'b0;
        chk("rxfull_drained", idx, 20);
        wait_xfer(xb, 100);
        chk("rxfull_total_starts", n_starts - sb, 20);

        // Overflow / underflow, sticky until reset
        do_reset();
        for (int i = 0; i < 16; i++) push_tx(8'(i));
        chk("ovf_before", ovf_err, 1'b0);
        chk("ovf_tx_full", tx_full, 1'b1);
        push_tx(8'hEE);
        chk("ovf_tx_push", ovf_err, 1'b1);
        tick(5);
        chk("ovf_sticky", ovf_err, 1'b1);
        do_reset();
        chk("ovf_cleared", ovf_err, 1'b0);
        rx_rd = 1'b1; tick(); rx_rd = 1'b0;
        chk("udf_rx_pop", ovf_err, 1'b1);
        tick(10);
        chk("udf_sticky", ovf_err, 1'b1);

        // Reset during WAIT_DONE of byte 2 of 4
        do_reset();
        sb = n_starts;
        for (int i = 0; i < 4; i++) push_tx(8'h61 + 8'(i));
        send_cmd(8'd3);
        wait_starts(sb + 2, 200);
        do_reset();
        chk("midrst_ss_n", ss_n, 1'b1);
        chk("midrst_rx_empty", rx_empty, 1'b1);
        chk("midrst_tx_full", tx_full, 1'b0);
        chk("midrst_cmd_ready", cmd_ready, 1'b1);
        xb = n_xfer;
        push_tx(8'h3C);
        send_cmd(8'd0);
        wait_xfer(xb, 100);
        tick();
        pop_chk("midrst_new_rx", 8'h3C);
        chk("midrst_rx_empty_end", rx_empty, 1'b1);

        tick(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_burst_ctrl.md
# spi_burst_ctrl

Multi-byte transaction controller sitting directly upstream of the byte-level `spi` master core. Accepts a burst command (byte count) from a host and asserts the active-low slave select `ss_n` with programmable setup/hold guard times. Streams bytes from a TX FIFO into the core's `din`/`start`/`ready` handshake and captures each `dout` on `spi_done_tick` into an RX FIFO. The core keeps ownership of `sclk`, `mosi`, `miso`, `cpol`, `cpha` and `dvsr`; this block only drives the byte handshake and `ss_n`.

## Interface
- `DEPTH`, 16: entries per FIFO, power of two, ≥2.
- `CS_CYC`, 4: `clk` cycles of `ss_n` setup before the first byte and hold after the last, ≥1.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- `cmd_valid`  in  1  burst request.
- `cmd_len`  in  8  bytes in burst minus one (0 → 1 byte, 255 → 256 bytes).
- `cmd_ready`  out  1  high in IDLE; a command is accepted when `cmd_valid && cmd_ready`.
- `tx_wr`  in  1  push `tx_data` into the TX FIFO.
- `tx_data`  in  8  TX byte.
- `tx_full`  out  1  TX FIFO full.
- `rx_rd`  in  1  pop the RX FIFO.
- `rx_data`  out  8  RX FIFO head (first-word fall-through).
- `rx_empty`  out  1  RX FIFO empty.
- `busy`  out  1  high from command accept through the end of CS_HOLD.
- `xfer_done`  out  1  one-cycle pulse at burst end.
- `ovf_err`  out  1  sticky: write to a full TX FIFO or pop of an empty RX FIFO.
- `ss_n`  out  1  slave select, active low.
- `spi_din`  out  8  to core `din`.
- `spi_start`  out  1  to core `start`; one-cycle pulse.
- `spi_ready`  in  1  from core `ready`.
- `spi_dout`  in  8  from core `dout`.
- `spi_done_tick`  in  1  from core `spi_done_tick`.

## Operation
- States: IDLE, CS_SETUP, LOAD, WAIT_DONE, CS_HOLD.
- **IDLE.** On accept: latch `remain = cmd_len` (8-bit), `ss_n` goes low, `gap = CS_CYC-1`, go to CS_SETUP.
- **CS_SETUP.** Decrement `gap`. At 0, go to LOAD.
- **LOAD.** Issue when `spi_ready && !tx_empty && !rx_full`. On issue: `spi_start=1`, `spi_din` = TX head, pop TX in the same cycle, go to WAIT_DONE. Otherwise stall; `ss_n` stays low with no timeout.
- **WAIT_DONE.** On `spi_done_tick`, push `spi_dout` into the RX FIFO.
  - If `remain==0`: go to CS_HOLD, `gap = CS_CYC-1`.
  - Else: decrement `remain`, go to LOAD.
- **CS_HOLD.** Decrement `gap`. At 0: `ss_n=1`, `xfer_done=1` for one cycle, go to IDLE.
- RX room is checked only at issue. One byte is outstanding at a time and the host can only pop, so room is guaranteed at done.
- **FIFOs.**
  - Simultaneous push and pop both occur; occupancy is unchanged.
  - Push to full is dropped and sets `ovf_err`; pop from empty is ignored and sets `ovf_err`.
  - Pointers wrap modulo `DEPTH`; a count of width log2(DEPTH)+1 distinguishes full from empty.
- TX writes are allowed in any state, including before the command.
- `cmd_valid` outside IDLE is ignored; no queuing.

## Timing
- Reset values:
  - `ss_n=1`, `spi_start=0`, `spi_din=0`, `busy=0`, `xfer_done=0`, `ovf_err=0`, `cmd_ready=1` (from the first cycle after reset).
  - Both FIFOs empty: `tx_full=0`, `rx_empty=1`, `rx_data=0`.
- Reset mid-burst: next cycle `ss_n=1` and the FIFOs are flushed; any in-flight `spi_done_tick` is ignored. The core shares the reset at top level.
- Accept cycle N: `ss_n` low and `busy` high at N+1. The first `spi_start` is no earlier than N+1+CS_CYC.
- `spi_start` to next `spi_start`: at least done + 1 cycle (WAIT_DONE→LOAD→issue).
- Last `spi_done_tick` at cycle M: `ss_n` rises and `xfer_done` pulses at M+CS_CYC; `busy` is low and `cmd_ready` high at M+CS_CYC+1.
- The RX byte is visible on `rx_data` (with `rx_empty=0`) the cycle after `spi_done_tick`.

## Structure
- `spi_pkg` holds the state enum `burst_state_e` and `SPI_BYTE_W=8`, shared with the `spi` core's byte width.
- One sub-module, `sync_fifo` (parameters WIDTH, DEPTH; FWFT; full/empty/count), instanced twice.
- FSM, `remain` and `gap` counters live in `spi_burst_ctrl`.

## Test plan
- **Single byte, loopback.** Stimulus: real `spi` core with `miso=mosi`, `dvsr=999`; push 0x55, command `cmd_len=0`. Response: one `spi_start`; `rx_data=0x55`; `ss_n` low exactly CS_CYC cycles before `start` and after done; one `xfer_done`.
- **4-byte burst.** Stimulus: 0xA1, 0xB2, 0xC3, 0xD4 pre-loaded. Response: four starts, `ss_n` continuously low, RX pops return the same order, `busy` deasserts after the 4th.
- **TX underrun.** Stimulus: `cmd_len=1` with only one byte pushed; second byte pushed 50 cycles later. Response: FSM stalls in LOAD with `ss_n` low and no `start`; resumes one cycle after the push.
- **RX full.** Stimulus: DEPTH=16, burst of 20, host not popping. Response: stall after 16 bytes with `rx_full`; one pop releases exactly one byte; no data loss.
- **Overflow/underflow.** Stimulus: 17 TX pushes while idle, then one `rx_rd` while empty. Response: 17th push dropped, `ovf_err=1` sticky until reset.
- **Reset mid-burst.** Stimulus: assert `reset` during WAIT_DONE of byte 2/4. Response: `ss_n=1` next cycle, FIFOs empty, `cmd_ready=1`; a new 1-byte burst completes correctly.
